// File: rtl/gate_op_pkg.sv
// gate_op_pkg: shared opcodes and FSM state type for the gate_op arbiter
package gate_op_pkg;
  localparam logic [2:0] OP_NAND = 3'd0;
  localparam logic [2:0] OP_NOT  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  typedef enum logic {IDLE, RESP} state_t;
endpackage

// File: rtl/gate_op_arbiter_if.sv
// gate_op_arbiter_if: request bus (req_valid/ready/op/a/b), response bus (rsp_valid/ready/id/data/err) and op_count
interface gate_op_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [3*NREQ-1:0]     req_op;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_err;
  logic [15:0]           op_count;
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, op_count
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, op_count
  );
endinterface

// File: rtl/gate_alu.sv
// gate_alu: combinational bitwise unit, in op/a/b, out y and err (opcodes 5..7 give y=0, err=1)
module gate_alu
  import gate_op_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             err
);
  always_comb begin
    y = op == OP_NAND ? ~(a & b) :
        op == OP_NOT  ? ~a :
        op == OP_AND  ? a & b :
        op == OP_OR   ? a | b :
        op == OP_XOR  ? a ^ b : '0;
    err = op > OP_XOR;
  end
endmodule

// File: rtl/gate_op_arbiter.sv
// gate_op_arbiter: round-robin share of one gate_alu among NREQ requesters; ports clk, rst_n, bus (slave: req_*, rsp_*, op_count)
module gate_op_arbiter
  import gate_op_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = $clog2(NREQ)
) (
  input logic             clk,
  input logic             rst_n,
  gate_op_arbiter_if.slave bus
);
  state_t           state, state_n;
  logic [IDW-1:0]   last_grant, g, idx;
  logic             accept_ok, grant, hs;
  logic [2:0]       op;
  logic [WIDTH-1:0] a, b, y;
  logic             err;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_err_q;
  logic [15:0]      op_count_q;
  // scan from farthest to nearest so the nearest valid requester after last_grant wins
  always_comb begin
    g = last_grant;
    idx = last_grant;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDW'((int'(last_grant) + k) % NREQ);
      g = bus.req_valid[idx] ? idx : g;
    end
    op = '0;
    a = '0;
    b = '0;
    for (int i = 0; i < NREQ; i++) begin
      op = g == IDW'(i) ? bus.req_op[3*i +: 3] : op;
      a = g == IDW'(i) ? bus.req_a[WIDTH*i +: WIDTH] : a;
      b = g == IDW'(i) ? bus.req_b[WIDTH*i +: WIDTH] : b;
    end
  end
  always_comb begin
    accept_ok = state == IDLE || bus.rsp_ready;
    grant = accept_ok && |bus.req_valid;
    hs = state == RESP && bus.rsp_ready;
    state_n = grant ? RESP : hs ? IDLE : state;
  end
  gate_alu #(.WIDTH(WIDTH)) u_alu (.op(op), .a(a), .b(b), .y(y), .err(err));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IDW'(NREQ - 1);
      rsp_id_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q <= 1'b0;
      op_count_q <= '0;
    end else begin
      if (grant) begin
        last_grant <= g;
        rsp_id_q <= g;
        rsp_data_q <= y;
        rsp_err_q <= err;
      end
      if (hs) op_count_q <= op_count_q + 16'd1;
    end
  end
  assign bus.req_ready = grant ? NREQ'(1) << g : '0;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_id = rsp_id_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_err = rsp_err_q;
  assign bus.op_count = op_count_q;
endmodule

// File: tb/tb_gate_op_arbiter.sv
// tb_gate_op_arbiter: scoreboard bench for gate_op_arbiter
module tb_gate_op_arbiter;
  import gate_op_pkg::*;
  localparam int NREQ = 4;
  localparam int WIDTH = 16;
  localparam int IDW = 2;
  typedef struct {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] data;
    logic             err;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  gate_op_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();
  gate_op_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  exp_t mon_e;
  int m_last;
  logic [15:0] m_count;
  bit m_resp;
  logic [NREQ-1:0] oneshot;
  function automatic logic [WIDTH:0] alu_ref(logic [2:0] op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    case (op)
      3'd0: return {1'b0, ~(a & b)};
      3'd1: return {1'b0, ~a};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      default: return {1'b1, {WIDTH{1'b0}}};
    endcase
  endfunction
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected got id=%0d data=%h err=%b want no response", bus.rsp_id, bus.rsp_data, bus.rsp_err);
      end else begin
        mon_e = q.pop_front();
        if (bus.rsp_id !== mon_e.id || bus.rsp_data !== mon_e.data || bus.rsp_err !== mon_e.err) begin
          failures++;
          $display("FAIL rsp_match got id=%0d data=%h err=%b want id=%0d data=%h err=%b",
                   bus.rsp_id, bus.rsp_data, bus.rsp_err, mon_e.id, mon_e.data, mon_e.err);
        end
      end
    end
  end
  task automatic set_req(int i, logic [2:0] op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, bit once);
    bus.req_op[3*i +: 3] = op;
    bus.req_a[WIDTH*i +: WIDTH] = a;
    bus.req_b[WIDTH*i +: WIDTH] = b;
    bus.req_valid[i] = 1'b1;
    oneshot[i] = once;
  endtask
  task automatic model_reset();
    m_last = NREQ - 1;
    m_count = '0;
    m_resp = 1'b0;
    q.delete();
  endtask
  task automatic step(output int g, output logic [NREQ-1:0] rr);
    int eg;
    bit hs;
    logic [NREQ-1:0] exp_rr;
    logic [WIDTH:0] r;
    @(negedge clk);
    eg = -1;
    if (!m_resp || bus.rsp_ready)
      for (int k = 1; k <= NREQ; k++)
        if (eg < 0 && bus.req_valid[(m_last + k) % NREQ]) eg = (m_last + k) % NREQ;
    exp_rr = eg < 0 ? '0 : NREQ'(1) << eg;
    rr = bus.req_ready;
    checks++;
    if (rr !== exp_rr) begin
      failures++;
      $display("FAIL req_ready got %b want %b", rr, exp_rr);
    end
    checks++;
    if (bus.rsp_valid !== m_resp) begin
      failures++;
      $display("FAIL rsp_valid got %b want %b", bus.rsp_valid, m_resp);
    end
    checks++;
    if (bus.op_count !== m_count) begin
      failures++;
      $display("FAIL op_count got %0d want %0d", bus.op_count, m_count);
    end
    hs = m_resp && bus.rsp_ready;
    if (hs) m_count = m_count + 16'd1;
    if (eg >= 0) begin
      r = alu_ref(bus.req_op[3*eg +: 3], bus.req_a[WIDTH*eg +: WIDTH], bus.req_b[WIDTH*eg +: WIDTH]);
      q.push_back('{id: IDW'(eg), data: r[WIDTH-1:0], err: r[WIDTH]});
      m_last = eg;
      m_resp = 1'b1;
    end else if (hs) m_resp = 1'b0;
    g = eg;
    @(posedge clk);
    #1;
    if (eg >= 0 && oneshot[eg]) bus.req_valid[eg] = 1'b0;
  endtask
  task automatic drain();
    int g;
    logic [NREQ-1:0] rr;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 20 && (bus.req_valid != 0 || m_resp); i++) step(g, rr);
    checks++;
    if (bus.req_valid != 0 || m_resp) begin
      failures++;
      $display("FAIL drain_timeout got valid=%b resp=%b want idle", bus.req_valid, m_resp);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    oneshot = '0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0 || bus.rsp_id !== '0 || bus.rsp_err !== 1'b0 ||
        bus.op_count !== '0 || bus.req_ready !== '0) begin
      failures++;
      $display("FAIL reset_state got valid=%b data=%h id=%0d err=%b cnt=%0d rr=%b want all zero",
               bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err, bus.op_count, bus.req_ready);
    end
  endtask
  task automatic test_single();
    int g;
    logic [NREQ-1:0] rr;
    bus.rsp_ready = 1'b1;
    set_req(0, OP_NAND, 16'h00FF, 16'h0F0F, 1'b1);
    step(g, rr);
    checks++;
    if (rr !== 4'b0001) begin
      failures++;
      $display("FAIL single_grant got %b want 0001", rr);
    end
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_data !== 16'hFFF0 || bus.rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL single_rsp got valid=%b id=%0d data=%h err=%b want 1 0 fff0 0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err);
    end
    step(g, rr);
    checks++;
    if (bus.op_count !== 16'd1) begin
      failures++;
      $display("FAIL single_count got %0d want 1", bus.op_count);
    end
  endtask
  task automatic test_rotation();
    int g;
    logic [NREQ-1:0] rr;
    logic [WIDTH-1:0] expd[5] = '{16'h5555, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h5555};
    logic [2:0] ops[4] = '{OP_NOT, OP_AND, OP_OR, OP_XOR};
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, ops[i], 16'hAAAA, 16'h5555, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(g, rr);
      checks++;
      if (rr !== NREQ'(1) << (i % NREQ) || bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'(i % NREQ) || bus.rsp_data !== expd[i]) begin
        failures++;
        $display("FAIL rotation_%0d got rr=%b valid=%b id=%0d data=%h want rr=%b valid=1 id=%0d data=%h",
                 i, rr, bus.rsp_valid, bus.rsp_id, bus.rsp_data, NREQ'(1) << (i % NREQ), i % NREQ, expd[i]);
      end
    end
    oneshot = '1;
    bus.req_valid = '0;
    drain();
  endtask
  task automatic test_illegal();
    int g;
    logic [NREQ-1:0] rr;
    logic [15:0] c0;
    c0 = m_count;
    bus.rsp_ready = 1'b1;
    set_req(2, 3'd6, 16'h1234, 16'h5678, 1'b1);
    step(g, rr);
    checks++;
    if (bus.rsp_err !== 1'b1 || bus.rsp_data !== 16'h0000 || bus.rsp_id !== 2'd2) begin
      failures++;
      $display("FAIL illegal_rsp got err=%b data=%h id=%0d want 1 0000 2", bus.rsp_err, bus.rsp_data, bus.rsp_id);
    end
    step(g, rr);
    checks++;
    if (bus.op_count !== c0 + 16'd1) begin
      failures++;
      $display("FAIL illegal_count got %0d want %0d", bus.op_count, c0 + 16'd1);
    end
  endtask
  task automatic test_hold();
    int g;
    logic [NREQ-1:0] rr;
    logic [WIDTH-1:0] d0;
    bus.rsp_ready = 1'b0;
    set_req(0, OP_AND, 16'hC3C3, 16'h0FF0, 1'b1);
    step(g, rr);
    d0 = bus.rsp_data;
    set_req(1, OP_OR, 16'h1111, 16'h2222, 1'b1);
    set_req(3, OP_XOR, 16'hFFFF, 16'h0F0F, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(g, rr);
      checks++;
      if (rr !== '0 || bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h03C0 || bus.rsp_data !== d0 || bus.rsp_id !== 2'd0) begin
        failures++;
        $display("FAIL hold_%0d got rr=%b valid=%b data=%h id=%0d want rr=0000 valid=1 data=03c0 id=0",
                 i, rr, bus.rsp_valid, bus.rsp_data, bus.rsp_id);
      end
    end
    bus.rsp_ready = 1'b1;
    step(g, rr);
    checks++;
    if (rr !== 4'b0010) begin
      failures++;
      $display("FAIL hold_release got %b want 0010", rr);
    end
    drain();
  endtask
  task automatic test_async_reset();
    int g;
    logic [NREQ-1:0] rr;
    bus.rsp_ready = 1'b0;
    set_req(1, OP_NOT, 16'h00FF, 16'h0000, 1'b1);
    step(g, rr);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.op_count !== 16'd0) begin
      failures++;
      $display("FAIL async_reset got valid=%b cnt=%0d want 0 0", bus.rsp_valid, bus.op_count);
    end
    model_reset();
    bus.req_valid = '0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, OP_OR, 16'(i), 16'h0100, 1'b1);
    bus.rsp_ready = 1'b1;
    step(g, rr);
    checks++;
    if (rr !== 4'b0001) begin
      failures++;
      $display("FAIL post_reset_grant got %b want 0001", rr);
    end
    drain();
  endtask
  task automatic test_wrap();
    int g;
    logic [NREQ-1:0] rr;
    do_reset();
    bus.rsp_ready = 1'b1;
    set_req(0, OP_XOR, 16'h1234, 16'h4321, 1'b0);
    for (int i = 0; i < 65536; i++) begin
      step(g, rr);
      set_req(0, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'b0);
    end
    checks++;
    if (bus.op_count !== 16'd65535) begin
      failures++;
      $display("FAIL wrap_pre got %0d want 65535", bus.op_count);
    end
    step(g, rr);
    checks++;
    if (bus.op_count !== 16'd0) begin
      failures++;
      $display("FAIL wrap got %0d want 0", bus.op_count);
    end
    oneshot = '1;
    bus.req_valid = '0;
    drain();
  endtask
  initial begin
    bus.req_valid = '0;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    oneshot = '0;
    model_reset();
    test_reset();
    test_single();
    test_rotation();
    test_illegal();
    test_hold();
    test_async_reset();
    test_wrap();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL missing_rsp got %0d outstanding want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
